// File: rtl/mult_div_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Optional build macro: MULTDIV_UNSIGNED_EN (adds multu/divu support).
package mult_div_pkg;

   localparam int WIDTH_DEF       = 32;
   localparam int LATENCY_MULT    = WIDTH_DEF + 3;
   localparam int LATENCY_DIVZERO = 1;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      ITER,
      FIX,
      DONE
   } state_t;

endpackage

// File: rtl/mult_div_abs.sv
// Combinational magnitude extract / conditional two's-complement negate.
// With sgn set a negative val yields its magnitude; flip forces a negate.
module mult_div_abs #(
   parameter int W = 32
) (
   input  logic [W-1:0] val,
   input  logic         sgn,
   input  logic         flip,
   output logic [W-1:0] res
);

   logic neg;

   assign neg = (sgn & val[W-1]) ^ flip;
   assign res = neg ? (~val + 1'b1) : val;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed multiply / restoring divide writing HI/LO.
// Optional build macro: MULTDIV_UNSIGNED_EN (adds is_unsigned input).
module mult_div_unit
   import mult_div_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             op_div,
`ifdef MULTDIV_UNSIGNED_EN
   input  logic             is_unsigned,
`endif
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   state_t state, state_nx;

   logic [CNT_W-1:0] cnt;
   logic             op_q, sa_q, sb_q;
   logic [WIDTH-1:0] ma_q, mb_q;
   logic [WIDTH-1:0] acc_hi, acc_lo;

   logic             uns, sa, sb, b_zero;
   logic [WIDTH-1:0] ma, mb;

`ifdef MULTDIV_UNSIGNED_EN
   assign uns = is_unsigned;
`else
   assign uns = 1'b0;
`endif

   assign sa     = a_in[WIDTH-1] & ~uns;
   assign sb     = b_in[WIDTH-1] & ~uns;
   assign b_zero = (b_in == '0);

   mult_div_abs #(.W(WIDTH)) u_abs_a (
      .val  (a_in),
      .sgn  (~uns),
      .flip (1'b0),
      .res  (ma)
   );

   mult_div_abs #(.W(WIDTH)) u_abs_b (
      .val  (b_in),
      .sgn  (~uns),
      .flip (1'b0),
      .res  (mb)
   );

   // Sign correction applied in FIX
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;

   mult_div_abs #(.W(2*WIDTH)) u_fix_prod (
      .val  ({acc_hi, acc_lo}),
      .sgn  (1'b0),
      .flip (sa_q ^ sb_q),
      .res  (prod_fix)
   );

   mult_div_abs #(.W(WIDTH)) u_fix_quo (
      .val  (acc_lo),
      .sgn  (1'b0),
      .flip (sa_q ^ sb_q),
      .res  (quo_fix)
   );

   mult_div_abs #(.W(WIDTH)) u_fix_rem (
      .val  (acc_hi),
      .sgn  (1'b0),
      .flip (sa_q),
      .res  (rem_fix)
   );

   // One shift-add step: add multiplicand on LSB, shift product right
   logic [WIDTH:0]     madd;
   logic [2*WIDTH-1:0] mult_nx;

   assign madd    = {1'b0, acc_hi} +
                    (acc_lo[0] ? {1'b0, ma_q} : {(WIDTH+1){1'b0}});
   assign mult_nx = {madd, acc_lo[WIDTH-1:1]};

   // One restoring step: remainder < divisor so WIDTH-bit subtract suffices
   logic [WIDTH:0]     shl;
   logic [WIDTH-1:0]   sub;
   logic               ge;
   logic [2*WIDTH-1:0] div_nx;

   assign shl    = {acc_hi, acc_lo[WIDTH-1]};
   assign sub    = shl[WIDTH-1:0] - mb_q;
   assign ge     = (shl >= {1'b0, mb_q});
   assign div_nx = ge ? {sub, acc_lo[WIDTH-2:0], 1'b1}
                      : {shl[WIDTH-1:0], acc_lo[WIDTH-2:0], 1'b0};

   always_ff @(posedge clk) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) state_nx = (op_div && b_zero) ? DONE : LOAD;
         end
         LOAD: begin
            busy     = 1'b1;
            state_nx = ITER;
         end
         ITER: begin
            busy = 1'b1;
            if (cnt == CNT_W'(WIDTH-1)) state_nx = FIX;
         end
         FIX: begin
            busy     = 1'b1;
            state_nx = DONE;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt      <= '0;
         op_q     <= 1'b0;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         ma_q     <= '0;
         mb_q     <= '0;
         acc_hi   <= '0;
         acc_lo   <= '0;
         hi       <= '0;
         lo       <= '0;
         div_zero <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= (state == DONE);
         unique case (state)
            IDLE: begin
               if (start) begin
                  op_q     <= op_div;
                  sa_q     <= sa;
                  sb_q     <= sb;
                  ma_q     <= ma;
                  mb_q     <= mb;
                  cnt      <= '0;
                  div_zero <= op_div && b_zero;
               end
            end
            LOAD: begin
               acc_hi <= '0;
               acc_lo <= op_q ? ma_q : mb_q;
            end
            ITER: begin
               cnt <= cnt + 1'b1;
               if (op_q) {acc_hi, acc_lo} <= div_nx;
               else      {acc_hi, acc_lo} <= mult_nx;
            end
            FIX: begin
               if (op_q) begin
                  hi <= rem_fix;
                  lo <= quo_fix;
               end else begin
                  {hi, lo} <= prod_fix;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit.
// Optional build macro: MULTDIV_UNSIGNED_EN (exercises multu).
module tb_mult_div_unit;
   import mult_div_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n, start, op_div, is_unsigned;
   logic [31:0] a_in, b_in;
   logic        busy, done, div_zero;
   logic [31:0] hi, lo;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   mult_div_unit dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start),
      .op_div   (op_div),
`ifdef MULTDIV_UNSIGNED_EN
      .is_unsigned (is_unsigned),
`endif
      .a_in     (a_in),
      .b_in     (b_in),
      .busy     (busy),
      .done     (done),
      .div_zero (div_zero),
      .hi       (hi),
      .lo       (lo)
   );

   // Issue one op and count edges until done (bounded); operands scrambled after start
   task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                         output int edges, output logic busy0);
      start = 1'b1; op_div = op; a_in = a; b_in = b;
      @(posedge clk); #1;
      start = 1'b0; a_in = $urandom; b_in = $urandom;
      busy0 = busy;
      edges = 0;
      while (!done && edges < 100) begin
         @(posedge clk); #1;
         edges++;
      end
   endtask

   task automatic test_reset;
      reset_n = 1'b0; start = 1'b0; op_div = 1'b0; is_unsigned = 1'b0;
      a_in = '0; b_in = '0;
      repeat (3) @(posedge clk);
      #1;
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b exp 0", done); end
      tests++; if (div_zero !== 1'b0) begin fails++; $display("FAIL reset_dz got %b exp 0", div_zero); end
      tests++; if ({hi, lo} !== 64'h0) begin fails++; $display("FAIL reset_hilo got %h exp 0", {hi, lo}); end
      reset_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_mult;
      int e; logic b0;
      run_op(1'b0, 32'd7, 32'hFFFFFFFD, e, b0);
      tests++; if (e !== LATENCY_MULT) begin fails++; $display("FAIL mult_lat got %0d exp %0d", e, LATENCY_MULT); end
      tests++; if (b0 !== 1'b1) begin fails++; $display("FAIL mult_busy1 got %b exp 1", b0); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mult_busy_done got %b exp 0", busy); end
      tests++; if (hi !== 32'hFFFFFFFF) begin fails++; $display("FAIL mult_neg_hi got %h exp FFFFFFFF", hi); end
      tests++; if (lo !== 32'hFFFFFFEB) begin fails++; $display("FAIL mult_neg_lo got %h exp FFFFFFEB", lo); end
      @(posedge clk); #1;
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL mult_done_pulse got %b exp 0", done); end
      run_op(1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, e, b0);
      tests++; if ({hi, lo} !== 64'h3FFFFFFF_00000001) begin fails++; $display("FAIL mult_max got %h exp 3FFFFFFF00000001", {hi, lo}); end
      run_op(1'b0, 32'h80000000, 32'h80000000, e, b0);
      tests++; if ({hi, lo} !== 64'h40000000_00000000) begin fails++; $display("FAIL mult_minmin got %h exp 4000000000000000", {hi, lo}); end
      run_op(1'b0, 32'h80000000, 32'd1, e, b0);
      tests++; if ({hi, lo} !== 64'hFFFFFFFF_80000000) begin fails++; $display("FAIL mult_min1 got %h exp FFFFFFFF80000000", {hi, lo}); end
   endtask

   task automatic test_div;
      int e; logic b0;
      run_op(1'b1, 32'hFFFFFFF9, 32'd2, e, b0);
      tests++; if (e !== LATENCY_MULT) begin fails++; $display("FAIL div_lat got %0d exp %0d", e, LATENCY_MULT); end
      tests++; if (lo !== 32'hFFFFFFFD) begin fails++; $display("FAIL div_neg_q got %h exp FFFFFFFD", lo); end
      tests++; if (hi !== 32'hFFFFFFFF) begin fails++; $display("FAIL div_neg_r got %h exp FFFFFFFF", hi); end
      run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, e, b0);
      tests++; if ({hi, lo} !== 64'h00000000_80000000) begin fails++; $display("FAIL div_ovf got %h exp 0000000080000000", {hi, lo}); end
      tests++; if (div_zero !== 1'b0) begin fails++; $display("FAIL div_ovf_dz got %b exp 0", div_zero); end
      run_op(1'b1, 32'd100, 32'd7, e, b0);
      tests++; if ({hi, lo} !== 64'h00000002_0000000E) begin fails++; $display("FAIL div_pos got %h exp 000000020000000E", {hi, lo}); end
      run_op(1'b1, 32'd7, 32'hFFFFFFFE, e, b0);
      tests++; if ({hi, lo} !== 64'h00000001_FFFFFFFD) begin fails++; $display("FAIL div_negb got %h exp 00000001FFFFFFFD", {hi, lo}); end
   endtask

   task automatic test_div_zero;
      int e; logic b0;
      run_op(1'b1, 32'd5, 32'd0, e, b0);
      tests++; if (e !== LATENCY_DIVZERO) begin fails++; $display("FAIL dz_lat got %0d exp %0d", e, LATENCY_DIVZERO); end
      tests++; if (div_zero !== 1'b1) begin fails++; $display("FAIL dz_flag got %b exp 1", div_zero); end
      tests++; if ({hi, lo} !== 64'h00000001_FFFFFFFD) begin fails++; $display("FAIL dz_hold got %h exp 00000001FFFFFFFD", {hi, lo}); end
      @(posedge clk); #1;
      tests++; if (div_zero !== 1'b1) begin fails++; $display("FAIL dz_sticky got %b exp 1", div_zero); end
      run_op(1'b0, 32'd2, 32'd3, e, b0);
      tests++; if (div_zero !== 1'b0) begin fails++; $display("FAIL dz_clear got %b exp 0", div_zero); end
      tests++; if ({hi, lo} !== 64'd6) begin fails++; $display("FAIL dz_next got %h exp 6", {hi, lo}); end
   endtask

   task automatic test_busy_start;
      int e;
      start = 1'b1; op_div = 1'b0; a_in = 32'd6; b_in = 32'd7;
      @(posedge clk); #1;
      start = 1'b0; a_in = 32'hDEADBEEF; b_in = 32'h12345678;
      repeat (4) @(posedge clk);
      #1;
      start = 1'b1; op_div = 1'b1; a_in = 32'd100; b_in = 32'd0;
      @(posedge clk); #1;
      start = 1'b0;
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL ign_busy got %b exp 1", busy); end
      tests++; if (div_zero !== 1'b0) begin fails++; $display("FAIL ign_dz got %b exp 0", div_zero); end
      tests++; if (lo !== 32'd6) begin fails++; $display("FAIL ign_lo_hold got %h exp 6", lo); end
      e = 5;
      while (!done && e < 100) begin
         @(posedge clk); #1;
         e++;
      end
      tests++; if (e !== LATENCY_MULT) begin fails++; $display("FAIL ign_lat got %0d exp %0d", e, LATENCY_MULT); end
      tests++; if ({hi, lo} !== 64'd42) begin fails++; $display("FAIL ign_result got %h exp 42", {hi, lo}); end
   endtask

   task automatic test_reset_mid;
      int e; logic b0;
      start = 1'b1; op_div = 1'b0; a_in = 32'h12345678; b_in = 32'h10;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (11) @(posedge clk);
      #1;
      reset_n = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rmid_busy got %b exp 0", busy); end
      tests++; if ({hi, lo} !== 64'h0) begin fails++; $display("FAIL rmid_hilo got %h exp 0", {hi, lo}); end
      repeat (40) @(posedge clk);
      #1;
      tests++; if (done !== 1'b0) begin fails++; $display("FAIL rmid_nodone got %b exp 0", done); end
      run_op(1'b0, 32'd3, 32'd4, e, b0);
      tests++; if (e !== LATENCY_MULT) begin fails++; $display("FAIL rmid_lat got %0d exp %0d", e, LATENCY_MULT); end
      tests++; if ({hi, lo} !== 64'd12) begin fails++; $display("FAIL rmid_next got %h exp 12", {hi, lo}); end
   endtask

`ifdef MULTDIV_UNSIGNED_EN
   task automatic test_unsigned;
      int e; logic b0;
      is_unsigned = 1'b1;
      run_op(1'b0, 32'hFFFFFFFF, 32'd2, e, b0);
      tests++; if ({hi, lo} !== 64'h00000001_FFFFFFFE) begin fails++; $display("FAIL multu got %h exp 00000001FFFFFFFE", {hi, lo}); end
      run_op(1'b1, 32'hFFFFFFF9, 32'd2, e, b0);
      tests++; if ({hi, lo} !== 64'h00000001_7FFFFFFC) begin fails++; $display("FAIL divu got %h exp 000000017FFFFFFC", {hi, lo}); end
      is_unsigned = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_div_zero();
      test_busy_start();
      test_reset_mid();
`ifdef MULTDIV_UNSIGNED_EN
      test_unsigned();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
